// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the two-master arbiter.
// Holds HTRANS/HBURST codes, HMSEL one-hot constants and burst length map.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    localparam logic [1:0] MSEL_M0 = 2'b10;
    localparam logic [1:0] MSEL_M1 = 2'b01;

    // Beats in a fixed-length burst; SINGLE and undefined INCR count as one.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        beats = 5'd1;
        unique case (hburst)
            HB_WRAP4,  HB_INCR4:  beats = 5'd4;
            HB_WRAP8,  HB_INCR8:  beats = 5'd8;
            HB_WRAP16, HB_INCR16: beats = 5'd16;
            default:              beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_arb_burst_cnt.sv
// Remaining-beat counter for the current fixed-length burst.
// burst_busy blocks re-arbitration while a burst is starting or in flight.
module ahb_arb_burst_cnt
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       hready,
    output logic       burst_busy
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] load_val;
    logic [4:0] beats_m1;
    logic       load_nz;

    // Next count: load on NONSEQ, step on SEQ, clear on IDLE, hold on BUSY.
    always_comb begin
        beats_m1 = burst_beats(hburst) - 5'd1;
        load_val = beats_m1[3:0];
        cnt_d    = cnt_q;
        if (hready) begin
            unique case (htrans)
                HT_NONSEQ: cnt_d = load_val;
                HT_SEQ:    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                HT_IDLE:   cnt_d = 4'd0;
                default:   cnt_d = cnt_q;
            endcase
        end
    end

    // The NONSEQ opening a multi-beat burst must not be followed by a handover,
    // so it counts as busy even though the register still reads zero.
    always_comb begin
        load_nz    = hready && (htrans == HT_NONSEQ) && (load_val != 4'd0);
        burst_busy = (cnt_q != 4'd0) || load_nz;
    end

    // Beat counter register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= 4'd0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ahb_arbiter2.sv
// Two-master AHB-Lite arbiter: grants, HMSEL/HMSEL_D pipeline, HMASTER, HMASTLOCK.
// Define AHB_ARB_RR_EN for round-robin; default build is fixed priority (M0).
module ahb_arbiter2
    import ahb_pkg::*;
#(
    parameter logic [3:0] MASTER0_ID = 4'd0,
    parameter logic [3:0] MASTER1_ID = 4'd1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HBUSREQ0,
    input  logic       HBUSREQ1,
    input  logic       HLOCK0,
    input  logic       HLOCK1,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    output logic       HGRANT0,
    output logic       HGRANT1,
    output logic [1:0] HMSEL,
    output logic [1:0] HMSEL_D,
    output logic [3:0] HMASTER,
    output logic       HMASTLOCK
);

    logic       gnt_q, gnt_d;
    logic [1:0] msel_q, msel_d;
    logic [1:0] msel_dq, msel_dd;
    logic [3:0] hmaster_q, hmaster_d;
    logic       mlock_q, mlock_d;
    logic       burst_busy;
    logic       hold_lock;
    logic       can_change;
    logic       win;
`ifdef AHB_ARB_RR_EN
    logic       ptr_q, ptr_d;
`endif

    ahb_arb_burst_cnt u_cnt (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .htrans     (HTRANS),
        .hburst     (HBURST),
        .hready     (HREADY),
        .burst_busy (burst_busy)
    );

    // Winner selection and grant hold; gnt_q is 1 when master 1 owns the grant.
    always_comb begin
        hold_lock  = gnt_q ? HLOCK1 : HLOCK0;
        can_change = !hold_lock && !burst_busy;
        win        = 1'b0;
        if (HBUSREQ0 && HBUSREQ1) begin
`ifdef AHB_ARB_RR_EN
            win = ~ptr_q;
`else
            win = 1'b0;
`endif
        end else if (HBUSREQ1) begin
            win = 1'b1;
        end
        gnt_d = can_change ? win : gnt_q;
`ifdef AHB_ARB_RR_EN
        ptr_d = (can_change && (HBUSREQ0 || HBUSREQ1)) ? win : ptr_q;
`endif
    end

    // Address/data ownership advances only on accepted (HREADY) edges.
    always_comb begin
        msel_d    = msel_q;
        msel_dd   = msel_dq;
        hmaster_d = hmaster_q;
        mlock_d   = mlock_q;
        if (HREADY) begin
            msel_d    = gnt_q ? MSEL_M1 : MSEL_M0;
            msel_dd   = msel_q;
            hmaster_d = gnt_q ? MASTER1_ID : MASTER0_ID;
            mlock_d   = gnt_q ? HLOCK1 : HLOCK0;
        end
    end

    // State registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gnt_q     <= 1'b0;
            msel_q    <= MSEL_M0;
            msel_dq   <= MSEL_M0;
            hmaster_q <= MASTER0_ID;
            mlock_q   <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            msel_q    <= msel_d;
            msel_dq   <= msel_dd;
            hmaster_q <= hmaster_d;
            mlock_q   <= mlock_d;
        end
    end

`ifdef AHB_ARB_RR_EN
    // Last-served pointer; resets to master 1 so master 0 wins first.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) ptr_q <= 1'b1;
        else          ptr_q <= ptr_d;
    end
`endif

    assign HGRANT0   = ~gnt_q;
    assign HGRANT1   = gnt_q;
    assign HMSEL     = msel_q;
    assign HMSEL_D   = msel_dq;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter2.sv
// Self-checking bench for ahb_arbiter2: directed scenarios then random traffic.
// Expected values come from a beat/owner-level reference model.
module tb_ahb_arbiter2;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       HBUSREQ0 = 1'b0, HBUSREQ1 = 1'b0;
    logic       HLOCK0 = 1'b0, HLOCK1 = 1'b0;
    logic [1:0] HTRANS = 2'b00;
    logic [2:0] HBURST = 3'd0;
    logic       HREADY = 1'b1;
    logic       HGRANT0, HGRANT1;
    logic [1:0] HMSEL, HMSEL_D;
    logic [3:0] HMASTER;
    logic       HMASTLOCK;

    int errors = 0;
    int checks = 0;

    // reference model state
    int         m_gnt, m_last, m_beats;
    logic [1:0] m_msel, m_mseld;
    logic [3:0] m_mast;
    logic       m_lock;

    always #5 HCLK = ~HCLK;

    ahb_arbiter2 dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ0  (HBUSREQ0),
        .HBUSREQ1  (HBUSREQ1),
        .HLOCK0    (HLOCK0),
        .HLOCK1    (HLOCK1),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT0   (HGRANT0),
        .HGRANT1   (HGRANT1),
        .HMSEL     (HMSEL),
        .HMSEL_D   (HMSEL_D),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    function automatic int blen(input logic [2:0] b);
        if (b >= 3'd6) return 16;
        if (b >= 3'd4) return 8;
        if (b >= 3'd2) return 4;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = 0; m_last = 1; m_beats = 0;
        m_msel = 2'b10; m_mseld = 2'b10; m_mast = 4'd0; m_lock = 1'b0;
    endtask

    task automatic model_edge();
        int  win, new_g;
        bit  lh, starting, may;
        lh       = (m_gnt == 0) ? HLOCK0 : HLOCK1;
        starting = HREADY && HTRANS == 2'b10 && blen(HBURST) > 1;
        may      = !lh && m_beats == 0 && !starting;
        new_g    = m_gnt;
        if (may) begin
            if (HBUSREQ0 && HBUSREQ1) begin
`ifdef AHB_ARB_RR_EN
                win = 1 - m_last;
`else
                win = 0;
`endif
            end else if (HBUSREQ1) win = 1;
            else win = 0;
            if (HBUSREQ0 || HBUSREQ1) m_last = win;
            new_g = win;
        end
        if (HREADY) begin
            case (HTRANS)
                2'b10: m_beats = blen(HBURST) - 1;
                2'b11: if (m_beats > 0) m_beats--;
                2'b00: m_beats = 0;
                default: ;
            endcase
            m_mseld = m_msel;
            m_msel  = (m_gnt == 0) ? 2'b10 : 2'b01;
            m_mast  = (m_gnt == 0) ? 4'd0 : 4'd1;
            m_lock  = (m_gnt == 0) ? HLOCK0 : HLOCK1;
        end
        m_gnt = new_g;
    endtask

    task automatic check_model();
        chk("grant0", {7'd0, HGRANT0}, {7'd0, m_gnt == 0});
        chk("grant1", {7'd0, HGRANT1}, {7'd0, m_gnt == 1});
        chk("hmsel", {6'd0, HMSEL}, {6'd0, m_msel});
        chk("hmsel_d", {6'd0, HMSEL_D}, {6'd0, m_mseld});
        chk("hmaster", {4'd0, HMASTER}, {4'd0, m_mast});
        chk("hmastlock", {7'd0, HMASTLOCK}, {7'd0, m_lock});
    endtask

    task automatic cyc();
        @(posedge HCLK);
        model_edge();
        #1 check_model();
        @(negedge HCLK);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_g0"}, {7'd0, HGRANT0}, 8'd1);
        chk({pfx, "_g1"}, {7'd0, HGRANT1}, 8'd0);
        chk({pfx, "_msel"}, {6'd0, HMSEL}, 8'h02);
        chk({pfx, "_mseld"}, {6'd0, HMSEL_D}, 8'h02);
        chk({pfx, "_mast"}, {4'd0, HMASTER}, 8'd0);
        chk({pfx, "_lock"}, {7'd0, HMASTLOCK}, 8'd0);
    endtask

    initial begin
        logic [3:0] exp_seq;
        model_reset();
        repeat (2) @(negedge HCLK);
        #1 chk_reset_outputs("rst");
        @(negedge HCLK);
        HRESETn = 1'b1;

        // master 1 alone: grant +1, address +2, data +3
        HBUSREQ1 = 1'b1;
        cyc(); chk("m1_grant", {7'd0, HGRANT1}, 8'd1);
        cyc(); chk("m1_msel", {6'd0, HMSEL}, 8'h01);
        chk("m1_mast", {4'd0, HMASTER}, 8'd1);
        cyc(); chk("m1_mseld", {6'd0, HMSEL_D}, 8'h01);
        HBUSREQ1 = 1'b0;
        cyc(); chk("park_m0", {7'd0, HGRANT0}, 8'd1);
        cyc();

        // master 0 INCR4 with master 1 requesting throughout
        HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1;
        HTRANS = 2'b10; HBURST = 3'd3;
        cyc(); chk("incr4_ns", {7'd0, HGRANT0}, 8'd1);
        HTRANS = 2'b11;
        cyc(); chk("incr4_s1", {7'd0, HGRANT0}, 8'd1);
        cyc(); chk("incr4_s2", {7'd0, HGRANT0}, 8'd1);
        HBUSREQ0 = 1'b0;
        cyc(); chk("incr4_s3", {7'd0, HGRANT0}, 8'd1);
        HTRANS = 2'b00;
        cyc(); chk("incr4_hand", {7'd0, HGRANT1}, 8'd1);

        // locked SINGLE transfers by master 1 while master 0 requests
        HLOCK1 = 1'b1; HBUSREQ0 = 1'b1;
        HTRANS = 2'b10; HBURST = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("lock_g1", {7'd0, HGRANT1}, 8'd1);
            chk("lock_ml", {7'd0, HMASTLOCK}, 8'd1);
        end
        HLOCK1 = 1'b0; HBUSREQ1 = 1'b0;
        cyc(); chk("unlock_g0", {7'd0, HGRANT0}, 8'd1);

        // both request, SINGLE transfers
        HBUSREQ1 = 1'b1;
`ifdef AHB_ARB_RR_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("both_g1", {7'd0, HGRANT1}, {7'd0, exp_seq[i]});
        end

        // reset mid INCR8 owned by master 1
        HBUSREQ0 = 1'b0; HTRANS = 2'b00;
        cyc(); cyc();
        HTRANS = 2'b10; HBURST = 3'd5;
        cyc();
        HTRANS = 2'b11; HBUSREQ0 = 1'b1;
        cyc(); cyc();
        #2 HRESETn = 1'b0;
        #1 chk_reset_outputs("arst");
        model_reset();
        @(negedge HCLK);
        HBUSREQ0 = 1'b0;
        HRESETn = 1'b1;
        cyc(); chk("post_rst_g1", {7'd0, HGRANT1}, 8'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            HBUSREQ0 = 1'($urandom_range(0, 1));
            HBUSREQ1 = 1'($urandom_range(0, 1));
            HLOCK0   = ($urandom_range(0, 7) == 0);
            HLOCK1   = ($urandom_range(0, 7) == 0);
            HTRANS   = 2'($urandom_range(0, 3));
            HBURST   = 3'($urandom_range(0, 7));
            HREADY   = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
